mole_round_ctrl: RTL
====================

Name: mole_round_ctrl

Overview:
- Sequences one whack-a-mole game on the DE10-Lite board.
- Picks a pseudo-random hole, lights its LED for a fixed window, and judges button presses as hit or miss.
- Keeps a BCD score for the HEX0/HEX1 decoders and ends the game after a fixed number of rounds.
- Sits between the debounced breadboard push buttons and the LEDR/7-segment drivers; owns the mole timer and the LFSR.

Parameters:
- MOLE_TICKS, 100000000, cycles a mole stays lit (2 s at 50 MHz).
- GAP_TICKS, 25000000, dark cycles between rounds.
- ROUNDS, 20, moles per game (1..99).
- NUM_HOLES, 9, number of holes/LEDs/buttons.
- LFSR_SEED, 4'b0001, LFSR reset value; must be non-zero.

Ports:
- cin, input, 1, system clock, 50 MHz.
- rst_n, input, 1, asynchronous active-low reset, driven from KEY[0].
- start, input, 1, one-cycle pulse that starts or restarts a game.
- btn_pulse, input, NUM_HOLES, one-cycle press pulses, already synchronised and debounced; bit i = hole i.
- led, output, NUM_HOLES, mole display; one-hot or zero.
- score_ones, output, 4, BCD ones digit.
- score_tens, output, 4, BCD tens digit.
- round_num, output, 7, rounds completed this game.
- hit_pulse, output, 1, one cycle per hit.
- miss_pulse, output, 1, one cycle per miss.
- busy, output, 1, high in PICK, SHOW and GAP.
- game_over, output, 1, high in DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; LFSR loads LFSR_SEED.
  - All outputs go to 0, including led, both score digits, round_num, busy and game_over.
  - Reset asserted mid-game aborts the game immediately.
- All outputs are registered and change one cycle after the causing event.
- LFSR:
  - 4-bit Fibonacci, taps x^4+x^3+1, free-running every cycle in every state.
  - Never all-zero.
- States: IDLE, PICK, SHOW, GAP, DONE.
- IDLE:
  - led=0.
  - start=1 → clear score and round_num, go to PICK.
- PICK:
  - cand = lfsr-1, range 0..14.
  - Accept when cand < NUM_HOLES and cand differs from the previous hole; otherwise stay in PICK and retry next cycle.
  - The first pick of a game has no previous-hole restriction.
  - On accept: store hole, clear timer, go to SHOW.
  - Worst case is bounded by the LFSR period (15 cycles).
- SHOW:
  - led = one-hot(hole); the timer increments each cycle.
  - Hit: btn_pulse[hole]=1 → hit_pulse, score +1, go to GAP. A hit takes priority over wrong buttons in the same cycle.
  - Wrong button: any other btn_pulse bit with no hit → miss_pulse, stay in SHOW, timer continues. Repeated wrong presses produce one miss_pulse each.
  - Timeout: timer == MOLE_TICKS-1 with no hit → miss_pulse, go to GAP.
  - A hit on the timeout cycle counts as a hit, and only hit_pulse is asserted.
- GAP:
  - led=0; timer counts GAP_TICKS cycles.
  - Button presses are ignored.
  - On expiry: round_num +1; if the new round_num == ROUNDS go to DONE, else go to PICK.
- DONE:
  - led=0, game_over=1, and score is held.
  - start → clear score and round_num, go to PICK.
- start is ignored in PICK, SHOW and GAP.
- Score:
  - Two-digit BCD; the ones digit wraps 9→0 with a carry into tens.
  - Saturates at 99.
- Timer:
  - Wide enough for max(MOLE_TICKS, GAP_TICKS); 27 bits at the defaults.
  - No overflow is possible.
- busy = state ∈ {PICK, SHOW, GAP}.

Decomposition:
- Package mole_pkg holds:
  - the state encoding, 3-bit enum;
  - NUM_HOLES;
  - the LFSR tap constant;
  - the BCD digit type.
- One sub-module: bcd_score_counter.
  - Handles the increment, clear and 99 saturation.
  - Outputs the ones and tens digits.
- The LFSR and FSM stay inline.

Test Plan (bench uses MOLE_TICKS=10, GAP_TICKS=4, ROUNDS=3, LFSR_SEED=1):
- Reset mid-SHOW: drop rst_n → same-cycle asynchronous clear; led=0, score=00, state IDLE, busy=0.
- Three correct hits:
  - start, then press the lit hole 2 cycles into each SHOW.
  - Required: 3 hit_pulse, score=03, round_num=3, game_over=1, led=0.
- All timeouts:
  - start with no presses.
  - Required: each SHOW lasts exactly 10 cycles, 3 miss_pulse, score=00, DONE after 3 rounds.
- Wrong then right:
  - In SHOW press a non-lit hole → miss_pulse, still SHOW.
  - Then press the lit hole → hit_pulse, score=01.
  - Simultaneous lit+unlit press → only hit_pulse.
- Boundary cases:
  - Hit on timer cycle 9 counts as a hit.
  - Presses during GAP produce no pulses.
  - start during SHOW is ignored.
  - Consecutive holes always differ, and the hole is always < 9.
- Score rollover, forced with ROUNDS=99 and all hits:
  - Score passes 09→10, reaches 99, game_over=1.
  - Restart via start gives score=00.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round controller.
//   state_t     : controller state encoding
//   NUM_HOLES   : default hole/LED/button count (must be <= 15, LFSR range)
//   LFSR_TAPS   : feedback mask for x^4 + x^3 + 1
//   bcd_digit_t : one BCD digit of the score display
package mole_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PICK = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int unsigned NUM_HOLES = 9;

    localparam logic [3:0] LFSR_TAPS = 4'b1100;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter, saturating at 99.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 00 (wins over inc)
//   inc        : add one point
//   ones, tens : BCD digits
module bcd_score_counter
    import mole_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t ones,
    output bcd_digit_t tens
);

    logic at_max;

    always_comb begin
        at_max = (ones == BCD_MAX) && (tens == BCD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
            tens <= '0;
        end else if (clr) begin
            ones <= '0;
            tens <= '0;
        end else if (inc && !at_max) begin
            if (ones == BCD_MAX) begin
                ones <= '0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole game sequencer.
//   cin        : system clock
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle pulse, starts/restarts a game from IDLE or DONE
//   btn_pulse  : debounced one-cycle press pulses, bit i = hole i
//   led        : lit mole, one-hot or zero
//   score_ones : BCD ones digit of the score
//   score_tens : BCD tens digit of the score
//   round_num  : rounds completed in this game
//   hit_pulse  : one cycle per hit
//   miss_pulse : one cycle per wrong press or timeout
//   busy       : game in progress (PICK, SHOW, GAP)
//   game_over  : final round finished (DONE)
module mole_round_ctrl #(
    parameter int unsigned MOLE_TICKS = 100000000,
    parameter int unsigned GAP_TICKS  = 25000000,
    parameter int unsigned ROUNDS     = 20,
    parameter int unsigned NUM_HOLES  = mole_pkg::NUM_HOLES,
    parameter logic [3:0]  LFSR_SEED  = 4'b0001
) (
    input  logic                 cin,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] btn_pulse,
    output logic [NUM_HOLES-1:0] led,
    output logic [3:0]           score_ones,
    output logic [3:0]           score_tens,
    output logic [6:0]           round_num,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 busy,
    output logic                 game_over
);

    import mole_pkg::*;

    localparam int unsigned TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] MOLE_LAST  = TW'(MOLE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [6:0]    ROUND_LAST = 7'(ROUNDS - 1);
    localparam logic [3:0]    HOLE_LIM   = 4'(NUM_HOLES);

    state_t        state;
    logic [3:0]    lfsr;
    logic [TW-1:0] timer;
    logic [3:0]    hole;
    logic          first_pick;

    logic [3:0]    cand;
    logic          cand_ok;
    logic          hit;
    logic          wrong;
    logic          start_game;

    always_comb begin
        cand       = lfsr - 4'd1;
        cand_ok    = (cand < HOLE_LIM) && (first_pick || (cand != hole));
        // led holds one-hot(hole) throughout SHOW, so it doubles as the hit mask
        hit        = (state == S_SHOW) && |(btn_pulse & led);
        wrong      = (state == S_SHOW) && |(btn_pulse & ~led);
        start_game = start && ((state == S_IDLE) || (state == S_DONE));
    end

    bcd_score_counter u_score (
        .clk   (cin),
        .rst_n (rst_n),
        .clr   (start_game),
        .inc   (hit),
        .ones  (score_ones),
        .tens  (score_tens)
    );

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lfsr       <= LFSR_SEED;
            timer      <= '0;
            hole       <= '0;
            first_pick <= 1'b1;
            led        <= '0;
            round_num  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            lfsr       <= {lfsr[2:0], ^(lfsr & LFSR_TAPS)};
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        round_num  <= '0;
                        first_pick <= 1'b1;
                        busy       <= 1'b1;
                        game_over  <= 1'b0;
                        led        <= '0;
                        state      <= S_PICK;
                    end
                end

                S_PICK: begin
                    if (cand_ok) begin
                        hole       <= cand;
                        first_pick <= 1'b0;
                        timer      <= '0;
                        led        <= NUM_HOLES'(1) << cand;
                        state      <= S_SHOW;
                    end
                end

                S_SHOW: begin
                    if (hit) begin
                        hit_pulse <= 1'b1;
                        led       <= '0;
                        timer     <= '0;
                        state     <= S_GAP;
                    end else begin
                        // a wrong press on the timeout cycle still yields a single miss
                        if (wrong || (timer == MOLE_LAST)) begin
                            miss_pulse <= 1'b1;
                        end
                        if (timer == MOLE_LAST) begin
                            led   <= '0;
                            timer <= '0;
                            state <= S_GAP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer     <= '0;
                        round_num <= round_num + 7'd1;
                        if (round_num == ROUND_LAST) begin
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_PICK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    led       <= '0;
                    busy      <= 1'b0;
                    game_over <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
